btn_debounce_sync: RTL and testbench
====================================

Name: btn_debounce_sync

Overview:
- Conditions a raw, asynchronous push-button or switch input into a clean, clock-synchronous level.
- Produces single-cycle rise/fall pulses and a wrapping press counter.
- Sits directly upstream of the single-bit registers in the design: btn_level or btn_rise drives their d input.
- Provides synchronization (2-FF), glitch rejection (stability counter) and edge detection.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronized cycles the input must hold a new value before it is accepted; legal range >= 1 (hardware builds override, e.g. 1_000_000).
- PRESS_W, 8, width of press_count.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button/switch level.
- btn_level  output  1  debounced, synchronized level.
- btn_rise  output  1  one-cycle pulse on each accepted 0->1 transition.
- btn_fall  output  1  one-cycle pulse on each accepted 1->0 transition.
- press_count  output  PRESS_W  number of accepted rises, modulo 2^PRESS_W.

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, port name reset. No asynchronous reset paths anywhere.
- Reset values: sync flops 0, FSM = S_LOW, counter 0, btn_level 0, btn_rise 0, btn_fall 0, press_count 0. Reset has priority over all other activity.
- Synchronizer: s1 <= btn_in; s2 <= s1. Only s2 is used downstream.
- Stability counter: cnt, width CNT_W = max(1, $clog2(STABLE_CYCLES)). Cleared on entry to any WAIT state.
- FSM states and transitions:
  - S_LOW: if s2==1 -> S_WAIT_HIGH, cnt <= 0; else stay.
  - S_WAIT_HIGH:
    - s2==0 -> S_LOW (glitch rejected; no output change).
    - s2==1 and cnt==STABLE_CYCLES-1 -> S_HIGH, btn_level <= 1, btn_rise <= 1, press_count <= press_count+1.
    - otherwise cnt <= cnt+1.
  - S_HIGH: if s2==0 -> S_WAIT_LOW, cnt <= 0; else stay.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH.
    - s2==1 -> S_HIGH (glitch rejected).
    - s2==0 and cnt==STABLE_CYCLES-1 -> S_LOW, btn_level <= 0, btn_fall <= 1.
    - otherwise cnt++.
- Outputs are all registered. btn_rise and btn_fall are 0 in every cycle other than the transition cycle, so each pulse is exactly 1 cycle wide.
- Latency: if btn_in is first sampled high at edge e0 and stays high, btn_level and btn_rise go high after edge e0+STABLE_CYCLES+2. With STABLE_CYCLES=4, that is 6 edges. Falling edges use the same latency.
- Glitch rule: a new value is accepted only if s2 holds it for STABLE_CYCLES+1 consecutive edges. This is counted from the edge on which the FSM leaves its IDLE state. Any shorter excursion leaves btn_level, the pulses and press_count unchanged.
- Width: press_count wraps from 2^PRESS_W-1 to 0 silently.
- Simultaneous events: at most one of btn_rise or btn_fall can be 1 in a cycle. A bounce during WAIT restarts counting from the opposite IDLE state.
- Reset mid-operation:
  - A WAIT state is abandoned and no pulse is produced.
  - If btn_in is held high through reset, after reset deassertion it goes through the full debounce and produces one btn_rise, and press_count becomes 1.
- STABLE_CYCLES==1 is legal: acceptance happens on the edge after WAIT entry.

Decomposition:
- Package btn_pkg holds:
  - typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW} btn_state_t;
  - function cnt_width(int n), returning max(1, $clog2(n)).
- One sub-module, sync_2ff (clk, reset, d, q). It is a 2-stage synchronizer with synchronous reset to 0 and is reusable for other async inputs.
- FSM, counter and output registers live in btn_debounce_sync.

Test Plan:
- Reset/idle: assert reset 3 cycles with btn_in=0, then release and hold btn_in=0 for 20 cycles -> all outputs 0 throughout, press_count=0.
- Clean press (STABLE_CYCLES=4): raise btn_in, keep it high 20 cycles -> btn_level=1 and btn_rise=1 exactly 6 edges after first sampling edge. btn_rise is high for exactly 1 cycle, press_count=1.
- Bounce rejection: btn_in high 3 cycles, low 2, high 3, low 10 -> btn_level stays 0, no pulses, press_count=0.
- Clean release after press: hold high 20, then low 20 -> btn_fall single pulse 6 edges after low is sampled, btn_level=0, press_count stays 1.
- Reset mid-debounce: btn_in high, assert reset 2 cycles during S_WAIT_HIGH while btn_in stays high -> no pulse during or immediately after reset. One btn_rise appears 6 edges after the first post-reset sampling edge, press_count=1.
- Wrap: PRESS_W=2, perform 5 clean presses -> press_count sequence 1,2,3,0,1 and exactly 5 btn_rise pulses.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the button debouncer.
package btn_pkg;

  // Debounce FSM: two stable idle states, each with a waiting state
  // that confirms a candidate new level.
  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } btn_state_t;

  // Stability counter width; never narrower than one bit so that
  // STABLE_CYCLES == 1 still yields a legal vector.
  function automatic int cnt_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_sync_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous input bit.
// Reusable for any other asynchronous level input.
module sync_2ff
  import btn_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Shift the raw input through two flops; only the second stage leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce_sync.sv
// Button/switch conditioner: synchronizes a raw input, rejects glitches
// shorter than the stability window, and emits a debounced level,
// single-cycle rise/fall pulses and a wrapping press counter.
module btn_debounce_sync
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PRESS_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  output logic               btn_level,
  output logic               btn_rise,
  output logic               btn_fall,
  output logic [PRESS_W-1:0] press_count
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic               btn_sync;

  btn_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [PRESS_W-1:0] count_q, count_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // State, counter and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: a candidate level must persist for the whole window
  // in a WAIT state; any reversal drops back to the idle state it came from.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;

    unique case (state_q)
      S_LOW: begin
        if (btn_sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end

      S_WAIT_HIGH: begin
        if (!btn_sync) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          count_d = count_q + PRESS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (!btn_sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end

      S_WAIT_LOW: begin
        if (btn_sync) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Directed testbench for btn_debounce_sync. Three instances share clk,
// reset and btn_in: default parameters, a 2-bit press counter (wrap),
// and STABLE_CYCLES=1 (minimum window).
module tb_btn_debounce_sync;

  logic       clk;
  logic       reset;
  logic       btn_in;

  logic       lvl_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic       lvl_w, rise_w, fall_w;
  logic [1:0] cnt_w;
  logic       lvl_1, rise_1, fall_1;
  logic [7:0] cnt_1;

  int vec_cnt = 0;
  int err_cnt = 0;

  btn_debounce_sync #(.STABLE_CYCLES(4), .PRESS_W(8)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl_a), .btn_rise(rise_a), .btn_fall(fall_a), .press_count(cnt_a)
  );

  btn_debounce_sync #(.STABLE_CYCLES(4), .PRESS_W(2)) dut_wrap (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl_w), .btn_rise(rise_w), .btn_fall(fall_w), .press_count(cnt_w)
  );

  btn_debounce_sync #(.STABLE_CYCLES(1), .PRESS_W(8)) dut_s1 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl_1), .btn_rise(rise_1), .btn_fall(fall_1), .press_count(cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns later and
  // inputs changed here are first sampled on the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_in = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++;
      if ({lvl_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
        err_cnt++;
        $display("FAIL reset_hold cyc=%0d got lvl=%b rise=%b fall=%b cnt=%0d want all 0",
                 i, lvl_a, rise_a, fall_a, cnt_a);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      vec_cnt++;
      if ({lvl_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
        err_cnt++;
        $display("FAIL reset_idle cyc=%0d got lvl=%b rise=%b fall=%b cnt=%0d want all 0",
                 i, lvl_a, rise_a, fall_a, cnt_a);
      end
    end
    $display("test_reset done: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_bounce();
    logic pattern [18];
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) pattern[k++] = 1'b1;
    for (int i = 0; i < 2; i++) pattern[k++] = 1'b0;
    for (int i = 0; i < 3; i++) pattern[k++] = 1'b1;
    for (int i = 0; i < 10; i++) pattern[k++] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      btn_in = pattern[i];
      step();
      vec_cnt++;
      if (lvl_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0 || cnt_a !== 8'd0) begin
        err_cnt++;
        $display("FAIL bounce cyc=%0d got lvl=%b rise=%b fall=%b cnt=%0d want 0/0/0/0",
                 i, lvl_a, rise_a, fall_a, cnt_a);
      end
    end
    $display("test_bounce done: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_clean_press();
    logic       exp_lvl, exp_rise, exp_lvl1, exp_rise1;
    logic [7:0] exp_cnt;
    btn_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_lvl   = (i >= 6);
      exp_rise  = (i == 6);
      exp_cnt   = (i >= 6) ? 8'd1 : 8'd0;
      exp_lvl1  = (i >= 3);
      exp_rise1 = (i == 3);
      vec_cnt++;
      if (lvl_a !== exp_lvl || rise_a !== exp_rise || fall_a !== 1'b0 || cnt_a !== exp_cnt) begin
        err_cnt++;
        $display("FAIL press edge=e0+%0d got lvl=%b rise=%b fall=%b cnt=%0d want lvl=%b rise=%b fall=0 cnt=%0d",
                 i, lvl_a, rise_a, fall_a, cnt_a, exp_lvl, exp_rise, exp_cnt);
      end
      vec_cnt++;
      if (lvl_1 !== exp_lvl1 || rise_1 !== exp_rise1 || fall_1 !== 1'b0) begin
        err_cnt++;
        $display("FAIL press_s1 edge=e0+%0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=0",
                 i, lvl_1, rise_1, fall_1, exp_lvl1, exp_rise1);
      end
    end
    $display("test_clean_press done: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_clean_release();
    logic exp_lvl, exp_fall;
    btn_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_lvl  = (i < 6);
      exp_fall = (i == 6);
      vec_cnt++;
      if (lvl_a !== exp_lvl || fall_a !== exp_fall || rise_a !== 1'b0 || cnt_a !== 8'd1) begin
        err_cnt++;
        $display("FAIL release edge=e0+%0d got lvl=%b rise=%b fall=%b cnt=%0d want lvl=%b rise=0 fall=%b cnt=1",
                 i, lvl_a, rise_a, fall_a, cnt_a, exp_lvl, exp_fall);
      end
    end
    $display("test_clean_release done: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_reset_mid();
    logic       exp_lvl, exp_rise;
    logic [7:0] exp_cnt;
    btn_in = 1'b1;
    // Four edges: the FSM is in S_WAIT_HIGH partway through counting.
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++;
      if (lvl_a !== 1'b0 || rise_a !== 1'b0) begin
        err_cnt++;
        $display("FAIL mid_pre edge=%0d got lvl=%b rise=%b want 0/0", i, lvl_a, rise_a);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vec_cnt++;
      if ({lvl_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
        err_cnt++;
        $display("FAIL mid_reset cyc=%0d got lvl=%b rise=%b fall=%b cnt=%0d want all 0",
                 i, lvl_a, rise_a, fall_a, cnt_a);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      exp_cnt  = (i >= 6) ? 8'd1 : 8'd0;
      vec_cnt++;
      if (lvl_a !== exp_lvl || rise_a !== exp_rise || fall_a !== 1'b0 || cnt_a !== exp_cnt) begin
        err_cnt++;
        $display("FAIL mid_post edge=e0+%0d got lvl=%b rise=%b fall=%b cnt=%0d want lvl=%b rise=%b fall=0 cnt=%0d",
                 i, lvl_a, rise_a, fall_a, cnt_a, exp_lvl, exp_rise, exp_cnt);
      end
    end
    $display("test_reset_mid done: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5];
    int         rises;
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
    exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
    rises = 0;
    btn_in = 1'b0;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int p = 0; p < 5; p++) begin
      btn_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        if (rise_w === 1'b1) rises++;
        if (i == 6) begin
          vec_cnt++;
          if (rise_w !== 1'b1 || cnt_w !== exp_seq[p]) begin
            err_cnt++;
            $display("FAIL wrap_press p=%0d got rise=%b cnt=%0d want rise=1 cnt=%0d",
                     p, rise_w, cnt_w, exp_seq[p]);
          end
        end
      end
      btn_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (rise_w === 1'b1) rises++;
      end
      vec_cnt++;
      if (lvl_w !== 1'b0 || cnt_w !== exp_seq[p]) begin
        err_cnt++;
        $display("FAIL wrap_release p=%0d got lvl=%b cnt=%0d want lvl=0 cnt=%0d",
                 p, lvl_w, cnt_w, exp_seq[p]);
      end
    end
    vec_cnt++;
    if (rises != 5) begin
      err_cnt++;
      $display("FAIL wrap_rises got %0d pulses want 5", rises);
    end
    $display("test_wrap done: vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    test_reset();
    test_bounce();
    test_clean_press();
    test_clean_release();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
